// File: rtl/rst_seq_multi_pkg.sv
// Shared types and helpers for the multi-domain reset sequencer.
package rst_seq_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_PD        = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rst_seq_multi_domain_hold.sv
// One fabric domain: soft-reset edge detect, hold down-counter and the
// active-low reset output register. Force beats release beats soft reset.
module rst_domain_hold
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_req,
  input  logic force_rst,
  input  logic rel_en,
  input  logic soft_en,
  output logic rst_n,
  output logic rst_n_next
);

  localparam int CW = cnt_w(HOLD_CYCLES - 1);

  logic          req_prev_q, req_prev_d;
  logic          rst_n_q, rst_n_d;
  logic          soft_q, soft_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_rise;

  assign req_rise   = sw_req & ~req_prev_q;
  assign rst_n      = rst_n_q;
  assign rst_n_next = rst_n_d;

  // Next-state for the edge detector, hold counter and output register.
  always_comb begin
    req_prev_d = sw_req;
    rst_n_d    = rst_n_q;
    soft_d     = soft_q;
    cnt_d      = cnt_q;
    if (force_rst) begin
      rst_n_d = 1'b0;
      soft_d  = 1'b0;
      cnt_d   = '0;
    end else if (rel_en) begin
      rst_n_d = 1'b1;
    end else if (soft_en && req_rise) begin
      // A fresh request while already held simply reloads the counter.
      rst_n_d = 1'b0;
      soft_d  = 1'b1;
      cnt_d   = CW'(HOLD_CYCLES - 1);
    end else if (soft_q) begin
      if (cnt_q == '0) begin
        rst_n_d = 1'b1;
        soft_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Domain state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev_q <= 1'b0;
      rst_n_q    <= 1'b0;
      soft_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      req_prev_q <= req_prev_d;
      rst_n_q    <= rst_n_d;
      soft_q     <= soft_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_seq_multi.sv
// Multi-domain fabric reset sequencer: PLL power-up, filtered lock wait,
// hold, staggered domain release, then run with per-domain soft reset.
//
//   state      | meaning
//   PD         | PLL held powered down for PD_CYCLES
//   WAIT_LOCK  | waiting for LOCK_FILTER stable lock cycles and init done
//   HOLD       | lock qualified, all domains held for HOLD_CYCLES
//   RELEASE    | domains released one by one, STAGE_GAP apart
//   RUN        | all released; soft resets serviced, lock monitored
module rst_seq_multi
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int PD_CYCLES   = 4,
  parameter int LOCK_FILTER = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PLL_LOCK,
  input  logic                   INIT_DONE,
  input  logic [NUM_DOMAINS-1:0] SW_RST_REQ,
  output logic                   PLL_POWERDOWN_B,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
  output logic                   ALL_READY,
  output logic [2:0]             SEQ_STATE,
  output logic [LOSS_CNT_W-1:0]  LOCK_LOSS_CNT
);

  localparam int PD_HOLD_MAX = (PD_CYCLES > HOLD_CYCLES) ? PD_CYCLES : HOLD_CYCLES;
  localparam int PHASE_MAX   = (PD_HOLD_MAX > STAGE_GAP) ? PD_HOLD_MAX : STAGE_GAP;
  localparam int CNT_W       = cnt_w(PHASE_MAX - 1);
  localparam int LCK_W       = cnt_w(LOCK_FILTER);
  localparam int IDX_W       = cnt_w(NUM_DOMAINS - 1);

  logic lock_m_q, lock_m_d, lock_s_q, lock_s_d;
  logic init_m_q, init_m_d, init_s_q, init_s_d;

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LCK_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   pd_b_q, pd_b_d;
  logic                   all_ready_q, all_ready_d;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;

  logic                   force_rst;
  logic                   soft_en;
  logic [NUM_DOMAINS-1:0] rel_en;
  logic [NUM_DOMAINS-1:0] dom_rst_n_d;

  assign PLL_POWERDOWN_B = pd_b_q;
  assign ALL_READY       = all_ready_q;
  assign SEQ_STATE       = state_q;
  assign LOCK_LOSS_CNT   = loss_cnt_q;

  // Sequencer next-state, phase counter, lock filter and domain controls.
  always_comb begin
    lock_m_d   = PLL_LOCK;
    lock_s_d   = lock_m_q;
    init_m_d   = INIT_DONE;
    init_s_d   = init_m_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_cnt_d = '0;
    idx_d      = idx_q;
    pd_b_d     = pd_b_q;
    loss_cnt_d = loss_cnt_q;
    force_rst  = 1'b1;
    soft_en    = 1'b0;
    rel_en     = '0;

    case (state_q)
      ST_PD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_LOCK;
          pd_b_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          lock_cnt_d = (lock_cnt_q == LCK_W'(LOCK_FILTER)) ? lock_cnt_q
                                                           : lock_cnt_q + LCK_W'(1);
        end
        if ((lock_cnt_d == LCK_W'(LOCK_FILTER)) && init_s_q) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end

      ST_HOLD: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end else if (cnt_q == '0) begin
          force_rst = 1'b0;
          rel_en[0] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
            idx_d   = IDX_W'(1);
            cnt_d   = CNT_W'(STAGE_GAP - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end else begin
          force_rst = 1'b0;
          if (cnt_q == '0) begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
              if (idx_q == IDX_W'(k)) rel_en[k] = 1'b1;
            end
            if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = CNT_W'(STAGE_GAP - 1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end else begin
          force_rst = 1'b0;
          soft_en   = 1'b1;
        end
      end

      default: begin
        state_d = ST_PD;
        cnt_d   = CNT_W'(PD_CYCLES - 1);
      end
    endcase
  end

  // Ready only when the next cycle is RUN and every domain is out of reset.
  always_comb begin
    all_ready_d = (state_d == ST_RUN) && (&dom_rst_n_d);
  end

  // Sequencer registers and input synchronisers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_m_q    <= 1'b0;
      lock_s_q    <= 1'b0;
      init_m_q    <= 1'b0;
      init_s_q    <= 1'b0;
      state_q     <= ST_PD;
      cnt_q       <= CNT_W'(PD_CYCLES - 1);
      lock_cnt_q  <= '0;
      idx_q       <= '0;
      pd_b_q      <= 1'b0;
      all_ready_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      lock_m_q    <= lock_m_d;
      lock_s_q    <= lock_s_d;
      init_m_q    <= init_m_d;
      init_s_q    <= init_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      idx_q       <= idx_d;
      pd_b_q      <= pd_b_d;
      all_ready_q <= all_ready_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dom
    rst_domain_hold #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
      .clk       (CLK),
      .rst       (RESET),
      .sw_req    (SW_RST_REQ[k]),
      .force_rst (force_rst),
      .rel_en    (rel_en[k]),
      .soft_en   (soft_en),
      .rst_n     (DOMAIN_RESET_N[k]),
      .rst_n_next(dom_rst_n_d[k])
    );
  end

endmodule

// File: tb/tb_rst_seq_multi.sv
// Bench for rst_seq_multi: timeline model derived from the sequencing rules,
// plus a soft-reset model that tracks per-domain release times.
module tb_rst_seq_multi;

  localparam int N      = 4;
  localparam int PD     = 4;
  localparam int LF     = 4;
  localparam int HOLD   = 16;
  localparam int GAP    = 8;
  localparam int T_HOLD = ((PD > 2) ? PD : 2) + LF;
  localparam int T_REL0 = T_HOLD + HOLD;
  localparam int T_RUN  = T_REL0 + (N - 1) * GAP;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         PLL_LOCK = 1'b0;
  logic         INIT_DONE = 1'b0;
  logic [N-1:0] SW_RST_REQ = '0;
  logic         PLL_POWERDOWN_B;
  logic [N-1:0] DOMAIN_RESET_N;
  logic         ALL_READY;
  logic [2:0]   SEQ_STATE;
  logic [7:0]   LOCK_LOSS_CNT;

  logic         RESET1 = 1'b1;
  logic         PLL_LOCK1 = 1'b1;
  logic         INIT_DONE1 = 1'b1;
  logic [0:0]   SW_RST_REQ1 = '0;
  logic         PLL_POWERDOWN_B1;
  logic [0:0]   DOMAIN_RESET_N1;
  logic         ALL_READY1;
  logic [2:0]   SEQ_STATE1;
  logic [7:0]   LOCK_LOSS_CNT1;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 CLK = ~CLK;

  rst_seq_multi #(.NUM_DOMAINS(N), .PD_CYCLES(PD), .LOCK_FILTER(LF),
                  .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP)) u_dut (
    .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
    .SW_RST_REQ(SW_RST_REQ), .PLL_POWERDOWN_B(PLL_POWERDOWN_B),
    .DOMAIN_RESET_N(DOMAIN_RESET_N), .ALL_READY(ALL_READY),
    .SEQ_STATE(SEQ_STATE), .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
  );

  rst_seq_multi #(.NUM_DOMAINS(1), .PD_CYCLES(PD), .LOCK_FILTER(LF),
                  .HOLD_CYCLES(HOLD), .STAGE_GAP(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET1), .PLL_LOCK(PLL_LOCK1), .INIT_DONE(INIT_DONE1),
    .SW_RST_REQ(SW_RST_REQ1), .PLL_POWERDOWN_B(PLL_POWERDOWN_B1),
    .DOMAIN_RESET_N(DOMAIN_RESET_N1), .ALL_READY(ALL_READY1),
    .SEQ_STATE(SEQ_STATE1), .LOCK_LOSS_CNT(LOCK_LOSS_CNT1)
  );

  // Phase of the sequence m edges after reset release, given when HOLD starts.
  function automatic int exp_phase(int m, int t_hold, int nd, int gap);
    if (m < PD) return 0;
    if (m < t_hold) return 1;
    if (m < t_hold + HOLD) return 2;
    if (m < t_hold + HOLD + (nd - 1) * gap) return 3;
    return 4;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    n++;
  endtask

  task automatic do_reset(input logic lock, input logic init);
    RESET = 1'b1;
    PLL_LOCK = lock;
    INIT_DONE = init;
    SW_RST_REQ = '0;
    repeat (2) step();
    RESET = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if (PLL_POWERDOWN_B !== 1'b0) begin errors++; $display("FAIL reset_pd_b got=%b exp=0", PLL_POWERDOWN_B); end
    checks++; if (DOMAIN_RESET_N !== '0) begin errors++; $display("FAIL reset_dom got=%b exp=0000", DOMAIN_RESET_N); end
    checks++; if (ALL_READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ALL_READY); end
    checks++; if (SEQ_STATE !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", SEQ_STATE); end
    checks++; if (LOCK_LOSS_CNT !== 8'd0) begin errors++; $display("FAIL reset_loss got=%0d exp=0", LOCK_LOSS_CNT); end
  endtask

  // Full power-up with random soft-reset requests that must be ignored before RUN.
  task automatic test_default();
    logic [N-1:0] exp_d;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < T_RUN + 4; i++) begin
      SW_RST_REQ = (n + 1 <= T_RUN) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      step();
      for (int k = 0; k < N; k++) exp_d[k] = (n >= T_REL0 + k * GAP);
      checks++; if (PLL_POWERDOWN_B !== (n >= PD)) begin errors++; $display("FAIL default_pd_b n=%0d got=%b exp=%b", n, PLL_POWERDOWN_B, (n >= PD)); end
      checks++; if (DOMAIN_RESET_N !== exp_d) begin errors++; $display("FAIL default_dom n=%0d got=%b exp=%b", n, DOMAIN_RESET_N, exp_d); end
      checks++; if (ALL_READY !== (n >= T_RUN)) begin errors++; $display("FAIL default_ready n=%0d got=%b exp=%b", n, ALL_READY, (n >= T_RUN)); end
      checks++; if (SEQ_STATE !== 3'(exp_phase(n, T_HOLD, N, GAP))) begin errors++; $display("FAIL default_state n=%0d got=%0d exp=%0d", n, SEQ_STATE, exp_phase(n, T_HOLD, N, GAP)); end
    end
  endtask

  task automatic test_soft_reset();
    int low2, lowar, others_bad, m;
    int soft_rel[N];
    logic [N-1:0] sp, sd, ed;
    low2 = 0; lowar = 0; others_bad = 0;
    SW_RST_REQ = 4'b0100;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) SW_RST_REQ = '0;
      if (DOMAIN_RESET_N[2] == 1'b0) low2++;
      if (ALL_READY == 1'b0) lowar++;
      if ({DOMAIN_RESET_N[3], DOMAIN_RESET_N[1:0]} != 3'b111) others_bad++;
    end
    checks++; if (low2 != HOLD) begin errors++; $display("FAIL soft_dom2_low got=%0d exp=%0d", low2, HOLD); end
    checks++; if (lowar != HOLD) begin errors++; $display("FAIL soft_ready_low got=%0d exp=%0d", lowar, HOLD); end
    checks++; if (others_bad != 0) begin errors++; $display("FAIL soft_others got=%0d exp=0", others_bad); end

    m = 0; sp = '0;
    for (int k = 0; k < N; k++) soft_rel[k] = 0;
    for (int i = 0; i < 200; i++) begin
      sd = sp;
      for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) sd[k] = ~sd[k];
      SW_RST_REQ = sd;
      step();
      m++;
      for (int k = 0; k < N; k++) begin
        if (sd[k] && !sp[k]) soft_rel[k] = m + HOLD;
        ed[k] = (m >= soft_rel[k]);
      end
      sp = sd;
      checks++; if (DOMAIN_RESET_N !== ed) begin errors++; $display("FAIL soft_rand_dom m=%0d got=%b exp=%b", m, DOMAIN_RESET_N, ed); end
      checks++; if (ALL_READY !== (&ed)) begin errors++; $display("FAIL soft_rand_ready m=%0d got=%b exp=%b", m, ALL_READY, &ed); end
    end
    SW_RST_REQ = '0;
    repeat (HOLD + 2) step();
    checks++; if ({ALL_READY, DOMAIN_RESET_N} !== {1'b1, {N{1'b1}}}) begin errors++; $display("FAIL soft_settle got=%b%b exp=1 1111", ALL_READY, DOMAIN_RESET_N); end
  endtask

  task automatic test_lock_filter();
    int g, c;
    do_reset(1'b0, 1'b1);
    for (int p = 0; p < 10; p++) begin
      g = $urandom_range(1, 3);
      for (int j = 0; j < 3 + g; j++) begin
        PLL_LOCK = (j < 3);
        step();
        checks++;
        if (DOMAIN_RESET_N !== '0 || SEQ_STATE !== ((n < PD) ? 3'd0 : 3'd1)) begin
          errors++; $display("FAIL filter_toggle n=%0d dom=%b state=%0d exp_state=%0d", n, DOMAIN_RESET_N, SEQ_STATE, (n < PD) ? 0 : 1);
        end
      end
    end
    PLL_LOCK = 1'b1;
    c = n;
    repeat (5) begin
      step();
      checks++; if (SEQ_STATE !== 3'd1) begin errors++; $display("FAIL filter_early n=%0d got=%0d exp=1", n - c, SEQ_STATE); end
    end
    step();
    checks++; if (SEQ_STATE !== 3'd2) begin errors++; $display("FAIL filter_hold_entry got=%0d exp=2", SEQ_STATE); end
  endtask

  task automatic test_lock_loss_release();
    int base;
    logic [N-1:0] exp_d;
    do_reset(1'b1, 1'b1);
    repeat (T_REL0 + GAP) step();
    checks++; if (DOMAIN_RESET_N !== 4'b0011) begin errors++; $display("FAIL loss_pre got=%b exp=0011", DOMAIN_RESET_N); end
    step();
    PLL_LOCK = 1'b0;
    repeat (2) begin
      step();
      checks++; if (DOMAIN_RESET_N !== 4'b0011) begin errors++; $display("FAIL loss_sync_delay got=%b exp=0011", DOMAIN_RESET_N); end
    end
    step();
    checks++; if (DOMAIN_RESET_N !== '0) begin errors++; $display("FAIL loss_dom got=%b exp=0000", DOMAIN_RESET_N); end
    checks++; if (LOCK_LOSS_CNT !== 8'd1) begin errors++; $display("FAIL loss_cnt got=%0d exp=1", LOCK_LOSS_CNT); end
    checks++; if (SEQ_STATE !== 3'd1 || PLL_POWERDOWN_B !== 1'b1) begin errors++; $display("FAIL loss_state got=%0d pd_b=%b exp=1 1", SEQ_STATE, PLL_POWERDOWN_B); end
    PLL_LOCK = 1'b1;
    base = n + 6;
    while (n < base + HOLD + (N - 1) * GAP + 2) begin
      step();
      for (int k = 0; k < N; k++) exp_d[k] = (n >= base + HOLD + k * GAP);
      checks++; if (DOMAIN_RESET_N !== exp_d) begin errors++; $display("FAIL relock_dom n=%0d got=%b exp=%b", n, DOMAIN_RESET_N, exp_d); end
      checks++; if (SEQ_STATE !== 3'(exp_phase(n, base, N, GAP))) begin errors++; $display("FAIL relock_state n=%0d got=%0d exp=%0d", n, SEQ_STATE, exp_phase(n, base, N, GAP)); end
    end
    checks++; if (ALL_READY !== 1'b1 || LOCK_LOSS_CNT !== 8'd1) begin errors++; $display("FAIL relock_end ready=%b cnt=%0d exp=1 1", ALL_READY, LOCK_LOSS_CNT); end
  endtask

  task automatic test_loss_saturate();
    int w, ll;
    do_reset(1'b1, 1'b1);
    for (int ev = 1; ev <= 300; ev++) begin
      w = 0;
      while (ALL_READY !== 1'b1 && w < 300) begin step(); w++; end
      checks++;
      if (ALL_READY !== 1'b1) begin errors++; $display("FAIL sat_wait_ready ev=%0d got=%b exp=1", ev, ALL_READY); break; end
      ll = $urandom_range(1, 3);
      PLL_LOCK = 1'b0;
      repeat (ll) step();
      PLL_LOCK = 1'b1;
      repeat (3) step();
      checks++;
      if (LOCK_LOSS_CNT !== 8'((ev > 255) ? 255 : ev)) begin
        errors++; $display("FAIL sat_cnt ev=%0d got=%0d exp=%0d", ev, LOCK_LOSS_CNT, (ev > 255) ? 255 : ev);
      end
    end
    w = 0;
    while (SEQ_STATE !== 3'd3 && w < 300) begin step(); w++; end
    checks++; if (SEQ_STATE !== 3'd3) begin errors++; $display("FAIL async_wait_release got=%0d exp=3", SEQ_STATE); end
    repeat (2) step();
    checks++; if (DOMAIN_RESET_N[0] !== 1'b1 || PLL_POWERDOWN_B !== 1'b1) begin errors++; $display("FAIL async_pre dom0=%b pd_b=%b exp=1 1", DOMAIN_RESET_N[0], PLL_POWERDOWN_B); end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({PLL_POWERDOWN_B, DOMAIN_RESET_N, ALL_READY, SEQ_STATE, LOCK_LOSS_CNT} !== '0) begin
      errors++; $display("FAIL async_reset pd_b=%b dom=%b ready=%b state=%0d cnt=%0d exp=all zero", PLL_POWERDOWN_B, DOMAIN_RESET_N, ALL_READY, SEQ_STATE, LOCK_LOSS_CNT);
    end
    step();
  endtask

  task automatic test_single_domain();
    localparam int T1_REL = T_HOLD + HOLD;
    step();
    RESET1 = 1'b0;
    n = 0;
    for (int i = 0; i < T1_REL + 4; i++) begin
      step();
      checks++; if (DOMAIN_RESET_N1[0] !== (n >= T1_REL)) begin errors++; $display("FAIL single_dom n=%0d got=%b exp=%b", n, DOMAIN_RESET_N1, (n >= T1_REL)); end
      checks++; if (ALL_READY1 !== (n >= T1_REL)) begin errors++; $display("FAIL single_ready n=%0d got=%b exp=%b", n, ALL_READY1, (n >= T1_REL)); end
      checks++; if (SEQ_STATE1 !== 3'(exp_phase(n, T_HOLD, 1, 1))) begin errors++; $display("FAIL single_state n=%0d got=%0d exp=%0d", n, SEQ_STATE1, exp_phase(n, T_HOLD, 1, 1)); end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default();
    test_soft_reset();
    test_lock_filter();
    test_lock_loss_release();
    test_loss_saturate();
    test_single_domain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
